load_store_unit: RTL
====================

# load_store_unit

Data-side memory responder for the RV32I core: accepts the load/store request produced by the control unit and datapath (size-coded byte enable, signed flag, write enable, ALU address), performs sub-word lane alignment, drives a single-outstanding req/gnt/rvalid bus to data memory, and returns aligned, sign- or zero-extended load data. It stalls the core for the duration of each access and sits between the execute stage and the data memory or bus.

## Interface
- ADDR_WIDTH, 32, byte address width; data width is fixed at 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  1  core requests a memory access this cycle.
- wr_en_i  in  1  1 = store, 0 = load.
- byte_en_i  in  4  size code: 4'b0001 = byte, 4'b0011 = half, 4'b1111 = word.
- signed_i  in  1  sign-extend load result (LB/LH); 0 = zero-extend (LBU/LHU).
- addr_i  in  ADDR_WIDTH  byte address from the ALU.
- wr_data_i  in  32  store data, right-justified.
- stall_o  out  1  hold the core's PC and pipeline.
- done_o  out  1  one-cycle pulse: access complete.
- rd_data_o  out  32  extended load result.
- misalign_o  out  1  request rejected: misaligned address or illegal size code.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write.
- mem_be_o  out  4  lane byte enables.
- mem_addr_o  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2], 2'b00}.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_gnt_i  in  1  bus accepts the request.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  raw read word.

## Operation
- Reset values: all outputs 0; state IDLE.
- Illegal request: byte_en_i not one of the three size codes, half with addr_i[0]=1, or word with addr_i[1:0]≠0.
  - misalign_o = req_i & illegal, combinational, in IDLE only.
  - No bus activity; state stays IDLE; stall_o is 0.
- States: IDLE, REQ, WAIT.
  - IDLE: on req_i & legal & ~done_o, latch all request fields → REQ.
  - REQ: mem_req_o = 1, with all bus fields stable until grant. On mem_gnt_i: a store → IDLE with done_o set next cycle; a load → WAIT.
  - WAIT: on mem_rvalid_i, register the extracted load into rd_data_o → IDLE with done_o set.
- Byte enables: mem_be_o = size code << addr[1:0].
- Store data, mem_wdata_o: byte → {4{wr_data[7:0]}}; half → {2{wr_data[15:0]}}; word → wr_data.
- Load extract: shift mem_rdata_i right by 8×addr[1:0], take 8/16/32 bits, then sign- or zero-extend per signed_i. The signed flag is ignored for word loads.
- rd_data_o holds its value until the next load completes; stores do not change it.
- stall_o = req_i & ~done_o & ~misalign_o.
  - A request held across done_o is not re-accepted, because the core advances on that edge.
- mem_rvalid_i outside WAIT and mem_gnt_i outside REQ are ignored.
- Reset mid-access: immediate return to IDLE with outputs cleared; a late rvalid is ignored.

## Timing
- All bus outputs and done_o/rd_data_o are registered; only stall_o and misalign_o are combinational.
- Store, zero-wait bus: accept at cycle 0, mem_req_o and gnt at cycle 1, done_o at cycle 2. Stall lasts 2 cycles.
- Load, zero-wait bus: accept at 0, req+gnt at 1, rvalid at 2, done_o and rd_data_o valid at 3. Stall lasts 3 cycles.
- Each gnt or rvalid wait cycle adds exactly one cycle.
- One outstanding access; back-to-back requests are separated by the done_o cycle.

## Structure
- Shared package lsu_pkg:
  - BE_BYTE/BE_HALF/BE_WORD constants, shared with main_decoder.
  - lsu_state_t enum {IDLE, REQ, WAIT}.
- Sub-module load_extend: combinational (raw word, offset, size, signed) → 32-bit result; reused by later cache work.

## Test plan
- SB, addr 0x1003, wr_data 0x000000AB → mem_addr 0x1000, be 4'b1000, wdata 0xABABABAB; done_o at cycle 2.
- LB signed, addr 0x2002, rdata 0x12F45678 → rd_data_o 0xFFFFFFF4; LBU on the same word → 0x000000F4.
- LH signed, addr 0x2002, rdata 0x80005678 → 0xFFFF8000; LW at 0x2000 with 3 gnt-wait and 2 rvalid-wait cycles → done_o at cycle 8.
- LW at 0x2001 or LH at 0x2003 → misalign_o=1, stall_o=0, mem_req_o never asserts.
- Assert rst_n low in WAIT, then a spurious rvalid after release → state IDLE, done_o=0, rd_data_o=0.
- Back-to-back SW then LW with req_i held → exactly one bus request each, no duplicate request in the done_o cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared size codes, state type and legality check for the LSU.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    // A size code is legal only when the access stays inside one aligned word.
    function automatic logic lsu_legal(input logic [3:0] size, input logic [1:0] off);
        case (size)
            BE_BYTE: return 1'b1;
            BE_HALF: return ~off[0];
            BE_WORD: return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Brief    : Single-outstanding req/gnt/rvalid data-memory bus.
// Revision : 1.0
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [31:0]           mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Brief    : Selects the addressed byte/half/word from a raw bus word and extends it.
// Revision : 1.0
// ============================================================================
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  offset_i,
    input  logic [3:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);
    logic [31:0] w_shifted;

    assign w_shifted = raw_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = w_shifted;
        case (size_i)
            BE_BYTE: data_o = {{24{signed_i & w_shifted[7]}},  w_shifted[7:0]};
            BE_HALF: data_o = {{16{signed_i & w_shifted[15]}}, w_shifted[15:0]};
            default: data_o = w_shifted;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I data-side LSU: aligns lanes, runs one bus access, extends loads.
// Revision : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  wr_en_i,
    input  logic [3:0]            byte_en_i,
    input  logic                  signed_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wr_data_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [31:0]           rd_data_o,
    output logic                  misalign_o,
    load_store_unit_if.master     mem
);
    lsu_state_t r_state, w_state_nxt;

    logic                  r_done;
    logic [31:0]           r_rd_data;
    logic                  r_mem_req;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_size;
    logic [1:0]            r_off;
    logic                  r_signed;

    logic        w_legal;
    logic        w_idle;
    logic        w_accept;
    logic        w_granted;
    logic        w_load_done;
    logic        w_done_set;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_load_data;

    assign w_legal    = lsu_legal(byte_en_i, addr_i[1:0]);
    assign w_idle     = (r_state == IDLE);
    assign misalign_o = req_i & ~w_legal & w_idle;
    // done_o marks the edge where the core advances, so a held request is not a new one.
    assign w_accept   = w_idle & req_i & w_legal & ~r_done;
    assign stall_o    = req_i & ~r_done & ~misalign_o;

    assign done_o          = r_done;
    assign rd_data_o       = r_rd_data;
    assign mem.mem_req_o   = r_mem_req;
    assign mem.mem_we_o    = r_we;
    assign mem.mem_be_o    = r_be;
    assign mem.mem_addr_o  = r_addr;
    assign mem.mem_wdata_o = r_wdata;

    always_comb begin
        w_wdata_rep = wr_data_i;
        case (byte_en_i)
            BE_BYTE: w_wdata_rep = {4{wr_data_i[7:0]}};
            BE_HALF: w_wdata_rep = {2{wr_data_i[15:0]}};
            default: w_wdata_rep = wr_data_i;
        endcase
    end

    load_extend u_load_extend (
        .raw_i    (mem.mem_rdata_i),
        .offset_i (r_off),
        .size_i   (r_size),
        .signed_i (r_signed),
        .data_o   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_granted   = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = REQ;
            end
            REQ: begin
                if (mem.mem_gnt_i) begin
                    w_granted   = 1'b1;
                    w_state_nxt = r_we ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid_i) begin
                    w_load_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_done_set = (w_granted & r_we) | w_load_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done    <= 1'b0;
            r_rd_data <= '0;
            r_mem_req <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= '0;
            r_off     <= '0;
            r_signed  <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_accept) begin
                r_mem_req <= 1'b1;
                r_we      <= wr_en_i;
                r_be      <= byte_en_i << addr_i[1:0];
                r_addr    <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                r_wdata   <= w_wdata_rep;
                r_size    <= byte_en_i;
                r_off     <= addr_i[1:0];
                r_signed  <= signed_i;
            end else if (w_granted) begin
                r_mem_req <= 1'b0;
            end
            if (w_load_done) r_rd_data <= w_load_data;
        end
    end
endmodule
`default_nettype wire
